uart_rx: RTL and testbench

Serial receiver for the CPU's UART transmit line. It deserialises frames into parallel words: idle-high line, one start bit (0), WIDTH data bits LSB first, one stop bit (1). Used in the FPGA top to loop CPU output back into the design, and in simulation benches in place of hand-written line sampling. Delivers each word on a valid/ready handshake and reports framing and overrun errors.

---
 rtl/uart_rx_pkg.sv | 19 +
 rtl/uart_rx_sync_2ff.sv | 27 ++
 rtl/uart_rx.sv | 141 ++++++++++++++
 tb/tb_uart_rx.sv | 250 +++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_rx_pkg.sv
// Shared UART definitions: FSM state encodings, default bit timing and frame-format constants.
// The transmitter imports this package too, so both ends agree on framing.
package uart_rx_pkg;

    typedef enum logic [2:0] {
        UART_IDLE  = 3'd0,
        UART_START = 3'd1,
        UART_DATA  = 3'd2,
        UART_STOP  = 3'd3,
        UART_BREAK = 3'd4
    } uart_state_t;

    // The CPU's UART runs at clk/2.
    localparam int UART_CLKS_PER_BIT = 2;

    localparam logic UART_START_BIT = 1'b0;
    localparam logic UART_STOP_BIT  = 1'b1;

endpackage

// File: rtl/uart_rx_sync_2ff.sv
// Two-flop synchroniser for a single asynchronous input.
// RESET_VAL should be the input's idle level so reset never looks like an edge.
module uart_rx_sync_2ff #(
    parameter logic RESET_VAL = 1'b1
) (
    input  logic i_clk,
    input  logic i_rst_n,
    input  logic i_d,
    output logic o_q
);

    logic r_meta;
    logic r_q;

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_meta <= RESET_VAL;
            r_q    <= RESET_VAL;
        end else begin
            r_meta <= i_d;
            r_q    <= r_meta;
        end
    end

    assign o_q = r_q;

endmodule

// File: rtl/uart_rx.sv
// UART receiver: idle-high line, start bit, WIDTH data bits LSB first, one stop bit.
// Words are delivered on a valid/ready handshake; framing and overrun errors are sticky.
//
// state      | meaning
// UART_IDLE  | waiting for the line to go low
// UART_START | confirming the start bit at half a bit period
// UART_DATA  | sampling data bits, one per CLKS_PER_BIT cycles
// UART_STOP  | sampling the stop bit; delivers the word or flags a framing error
// UART_BREAK | line held low after a bad stop bit; wait for it to go high
module uart_rx
    import uart_rx_pkg::*;
#(
    parameter int WIDTH        = 8,
    parameter int CLKS_PER_BIT = UART_CLKS_PER_BIT,
    parameter int HALF_BIT     = CLKS_PER_BIT / 2
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic             i_rx_line,
    output logic [WIDTH-1:0] o_out_data,
    output logic             o_out_valid,
    input  logic             i_out_ready,
    output logic             o_busy,
    output logic             o_frame_err,
    output logic             o_overrun,
    input  logic             i_err_clr
);

    localparam int CYC_W = $clog2(CLKS_PER_BIT);
    localparam int BIT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    localparam logic [CYC_W-1:0] CYC_LAST = CYC_W'(CLKS_PER_BIT - 1);
    localparam logic [CYC_W-1:0] CYC_HALF = CYC_W'(HALF_BIT - 1);
    localparam logic [BIT_W-1:0] BIT_LAST = BIT_W'(WIDTH - 1);

    uart_state_t      r_state;
    logic [CYC_W-1:0] r_cyc_cnt;
    logic [BIT_W-1:0] r_bit_cnt;
    logic [WIDTH-1:0] r_shift;
    logic [WIDTH-1:0] r_out_data;
    logic             r_out_valid;
    logic             r_frame_err;
    logic             r_overrun;
    logic             w_rx_s;

    uart_rx_sync_2ff #(
        .RESET_VAL (1'b1)
    ) u_sync (
        .i_clk   (i_clk),
        .i_rst_n (i_rst_n),
        .i_d     (i_rx_line),
        .o_q     (w_rx_s)
    );

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_state     <= UART_IDLE;
            r_cyc_cnt   <= '0;
            r_bit_cnt   <= '0;
            r_shift     <= '0;
            r_out_data  <= '0;
            r_out_valid <= 1'b0;
            r_frame_err <= 1'b0;
            r_overrun   <= 1'b0;
        end else begin
            // Clears and consumes come first so a same-cycle set or delivery overrides them.
            if (i_err_clr) begin
                r_frame_err <= 1'b0;
                r_overrun   <= 1'b0;
            end
            if (r_out_valid && i_out_ready) begin
                r_out_valid <= 1'b0;
            end

            case (r_state)
                UART_IDLE: begin
                    if (w_rx_s == UART_START_BIT) begin
                        r_state   <= UART_START;
                        r_cyc_cnt <= '0;
                    end
                end
                UART_START: begin
                    if (r_cyc_cnt == CYC_HALF) begin
                        r_cyc_cnt <= '0;
                        r_bit_cnt <= '0;
                        r_state   <= (w_rx_s == UART_START_BIT) ? UART_DATA : UART_IDLE;
                    end else begin
                        r_cyc_cnt <= r_cyc_cnt + CYC_W'(1);
                    end
                end
                UART_DATA: begin
                    if (r_cyc_cnt == CYC_LAST) begin
                        r_shift[r_bit_cnt] <= w_rx_s;
                        r_cyc_cnt          <= '0;
                        if (r_bit_cnt == BIT_LAST) begin
                            r_state <= UART_STOP;
                        end else begin
                            r_bit_cnt <= r_bit_cnt + BIT_W'(1);
                        end
                    end else begin
                        r_cyc_cnt <= r_cyc_cnt + CYC_W'(1);
                    end
                end
                UART_STOP: begin
                    if (r_cyc_cnt == CYC_LAST) begin
                        r_cyc_cnt <= '0;
                        if (w_rx_s == UART_STOP_BIT) begin
                            r_state <= UART_IDLE;
                            if (!r_out_valid || i_out_ready) begin
                                r_out_data  <= r_shift;
                                r_out_valid <= 1'b1;
                            end else begin
                                r_overrun <= 1'b1;
                            end
                        end else begin
                            r_frame_err <= 1'b1;
                            r_state     <= UART_BREAK;
                        end
                    end else begin
                        r_cyc_cnt <= r_cyc_cnt + CYC_W'(1);
                    end
                end
                UART_BREAK: begin
                    if (w_rx_s == UART_STOP_BIT) begin
                        r_state <= UART_IDLE;
                    end
                end
                default: begin
                    r_state <= UART_IDLE;
                end
            endcase
        end
    end

    assign o_out_data  = r_out_data;
    assign o_out_valid = r_out_valid;
    assign o_busy      = (r_state != UART_IDLE);
    assign o_frame_err = r_frame_err;
    assign o_overrun   = r_overrun;

endmodule

// File: tb/tb_uart_rx.sv
// Directed bench for uart_rx: a CLKS_PER_BIT=2 instance for framing/handshake cases
// and a CLKS_PER_BIT=8 instance for start-bit glitch rejection.
module tb_uart_rx;

    localparam int CPB = 2;

    logic       clk;
    logic       rst_n;
    logic       rx;
    logic [7:0] out_data;
    logic       out_valid;
    logic       out_ready;
    logic       busy;
    logic       frame_err;
    logic       overrun;
    logic       err_clr;

    logic       rx8;
    logic [7:0] out_data8;
    logic       out_valid8;
    logic       out_ready8;
    logic       busy8;
    logic       frame_err8;
    logic       overrun8;
    logic       err_clr8;

    int         n_checks;
    int         n_pass;
    logic [7:0] got_q[$];

    uart_rx #(.WIDTH(8), .CLKS_PER_BIT(CPB)) u_dut (
        .i_clk       (clk),
        .i_rst_n     (rst_n),
        .i_rx_line   (rx),
        .o_out_data  (out_data),
        .o_out_valid (out_valid),
        .i_out_ready (out_ready),
        .o_busy      (busy),
        .o_frame_err (frame_err),
        .o_overrun   (overrun),
        .i_err_clr   (err_clr)
    );

    uart_rx #(.WIDTH(8), .CLKS_PER_BIT(8)) u_dut8 (
        .i_clk       (clk),
        .i_rst_n     (rst_n),
        .i_rx_line   (rx8),
        .o_out_data  (out_data8),
        .o_out_valid (out_valid8),
        .i_out_ready (out_ready8),
        .o_busy      (busy8),
        .o_frame_err (frame_err8),
        .o_overrun   (overrun8),
        .i_err_clr   (err_clr8)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Record every accepted word; the handshake completes on the following posedge.
    always @(negedge clk) begin
        if (rst_n && out_valid && out_ready) got_q.push_back(out_data);
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        else n_pass++;
    endtask

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic send_frame(input logic [7:0] d, input logic stop_bit);
        rx = 1'b0;
        step(CPB);
        for (int i = 0; i < 8; i++) begin
            rx = d[i];
            step(CPB);
        end
        rx = stop_bit;
        step(CPB);
    endtask

    task automatic wait_words(input int n);
        int cyc;
        cyc = 0;
        while (got_q.size() < n && cyc < 200) begin
            step(1);
            cyc++;
        end
        chk("wait_words", 32'(got_q.size() >= n), 32'd1);
    endtask

    initial begin
        logic       seen;
        logic [7:0] v;
        n_checks   = 0;
        n_pass     = 0;
        rst_n      = 1'b0;
        rx         = 1'b1;
        rx8        = 1'b1;
        out_ready  = 1'b1;
        out_ready8 = 1'b1;
        err_clr    = 1'b0;
        err_clr8   = 1'b0;
        step(3);
        rst_n = 1'b1;
        step(2);

        chk("rst_data",  out_data,  8'h00);
        chk("rst_valid", out_valid, 1'b0);
        chk("rst_busy",  busy,      1'b0);
        chk("rst_ferr",  frame_err, 1'b0);
        chk("rst_ovr",   overrun,   1'b0);

        // Walking-one frames, back to back.
        got_q.delete();
        for (int i = 0; i < 8; i++) begin
            v = 8'h01 << i;
            send_frame(v, 1'b1);
        end
        wait_words(8);
        step(4);
        chk("shift_count", got_q.size(), 8);
        for (int i = 0; i < 8; i++) begin
            v = 8'h01 << i;
            if (i < got_q.size()) chk($sformatf("shift_word%0d", i), got_q[i], v);
        end
        chk("shift_ferr", frame_err, 1'b0);
        chk("shift_ovr",  overrun,   1'b0);

        // Bad stop bit followed by a held-low line.
        got_q.delete();
        send_frame(8'hA5, 1'b0);
        step(20);
        chk("ferr_break_busy", busy,         1'b1);
        chk("ferr_set",        frame_err,    1'b1);
        chk("ferr_no_word",    got_q.size(), 0);
        rx = 1'b1;
        step(5);
        chk("ferr_busy_drop",  busy,         1'b0);
        send_frame(8'h3C, 1'b1);
        wait_words(1);
        if (got_q.size() > 0) chk("ferr_next_word", got_q[0], 8'h3C);
        chk("ferr_next_data",  out_data,  8'h3C);
        chk("ferr_sticky",     frame_err, 1'b1);
        err_clr = 1'b1;
        step(1);
        err_clr = 1'b0;
        chk("ferr_clr",        frame_err, 1'b0);

        // Two-cycle low glitch on the slow instance.
        seen = 1'b0;
        rx8 = 1'b0;
        step(1);
        seen |= busy8;
        step(1);
        seen |= busy8;
        rx8 = 1'b1;
        for (int i = 0; i < 20; i++) begin
            step(1);
            seen |= busy8;
        end
        chk("glitch_busy_pulse", seen,       1'b1);
        chk("glitch_idle",       busy8,      1'b0);
        chk("glitch_no_valid",   out_valid8, 1'b0);
        chk("glitch_ferr",       frame_err8, 1'b0);
        chk("glitch_ovr",        overrun8,   1'b0);

        // Overrun with the consumer stalled.
        got_q.delete();
        out_ready = 1'b0;
        send_frame(8'h11, 1'b1);
        send_frame(8'h22, 1'b1);
        step(5);
        chk("ovr_data",  out_data,  8'h11);
        chk("ovr_valid", out_valid, 1'b1);
        chk("ovr_flag",  overrun,   1'b1);
        out_ready = 1'b1;
        step(1);
        out_ready = 1'b0;
        chk("ovr_consumed", out_valid, 1'b0);
        err_clr = 1'b1;
        step(1);
        err_clr = 1'b0;
        chk("ovr_clr", overrun, 1'b0);

        // Consume the held word exactly on the next word's delivery edge
        // (start driven after P0, delivered on posedge P22 at CPB=2).
        got_q.delete();
        send_frame(8'h55, 1'b1);
        step(5);
        chk("sim_hold_valid", out_valid, 1'b1);
        chk("sim_hold_data",  out_data,  8'h55);
        fork
            send_frame(8'h66, 1'b1);
            begin
                step(21);
                out_ready = 1'b1;
                step(1);
                out_ready = 1'b0;
            end
        join
        step(3);
        chk("sim_data",  out_data,     8'h66);
        chk("sim_valid", out_valid,    1'b1);
        chk("sim_ovr",   overrun,      1'b0);
        chk("sim_count", got_q.size(), 1);
        if (got_q.size() > 0) chk("sim_first", got_q[0], 8'h55);
        out_ready = 1'b1;
        step(2);

        // Reset during bit 4 of 0xF0 abandons that frame.
        got_q.delete();
        fork
            send_frame(8'hF0, 1'b1);
            begin
                step(11);
                rst_n = 1'b0;
                step(1);
                rst_n = 1'b1;
            end
        join
        step(5);
        chk("rstmid_nothing", got_q.size(), 0);
        chk("rstmid_busy",    busy,         1'b0);
        send_frame(8'h0F, 1'b1);
        wait_words(1);
        step(3);
        chk("rstmid_count", got_q.size(), 1);
        if (got_q.size() > 0) chk("rstmid_word", got_q[0], 8'h0F);
        chk("rstmid_ferr", frame_err, 1'b0);
        chk("rstmid_ovr",  overrun,   1'b0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
